// File: rtl/snes_pad_reader.sv
// SNES controller serial reader: drives latch/clock, shifts in 16 bits, and
// publishes a validated active-high button word with a presence flag and strobe.
module snes_pad_reader #(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic        clk,
    input  logic        nreset,
    output logic        nesc,
    output logic        nesl,
    input  logic        nesd,
    output logic [15:0] buttons,
    output logic        connected,
    output logic        valid
);

    localparam int MAX_LH  = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int MAX_ALL = (POLL_CYCLES > MAX_LH) ? POLL_CYCLES : MAX_LH;
    localparam int CW      = $clog2(MAX_ALL);

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_LATCH  = 3'd0,
        ST_WAIT0  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4,
        ST_IDLE   = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_phase;
    logic [CW-1:0] r_poll;
    logic [3:0]    r_bit_idx;
    logic [15:0]   r_raw;
    logic          r_nesd_meta;
    logic          r_nesd_s;

    logic          w_half_end;
    logic          w_nesc;
    logic          w_nesl;
    logic          w_sample_first;
    logic          w_sample_next;
    logic          w_present;

    assign w_half_end = (r_phase == HALF_LAST);
    assign w_present  = (r_raw[15:12] == 4'b1111);

    // Two-flop synchronizer for the asynchronous pad data line.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_nesd_meta <= 1'b1;
            r_nesd_s    <= 1'b1;
        end else begin
            r_nesd_meta <= nesd;
            r_nesd_s    <= r_nesd_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_LATCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LATCH: begin
                if (r_phase == LATCH_LAST) w_state_next = ST_WAIT0;
                else                       w_state_next = ST_LATCH;
            end
            ST_WAIT0: begin
                if (w_half_end) w_state_next = ST_CLK_LO;
                else            w_state_next = ST_WAIT0;
            end
            ST_CLK_LO: begin
                if (w_half_end) w_state_next = ST_CLK_HI;
                else            w_state_next = ST_CLK_LO;
            end
            ST_CLK_HI: begin
                if (w_half_end && (r_bit_idx == 4'd15)) w_state_next = ST_DONE;
                else if (w_half_end)                    w_state_next = ST_CLK_LO;
                else                                    w_state_next = ST_CLK_HI;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (r_poll == POLL_LAST) w_state_next = ST_LATCH;
                else                     w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_LATCH;
            end
        endcase
    end

    // Pin levels and sample strobes decoded from the current state.
    always_comb begin
        w_nesc         = 1'b1;
        w_nesl         = 1'b0;
        w_sample_first = 1'b0;
        w_sample_next  = 1'b0;
        case (r_state)
            ST_LATCH: begin
                w_nesl = 1'b1;
            end
            ST_WAIT0: begin
                w_sample_first = w_half_end;
            end
            ST_CLK_LO: begin
                w_nesc = 1'b0;
            end
            ST_CLK_HI: begin
                w_sample_next = w_half_end;
            end
            ST_DONE: begin
                w_nesc = 1'b1;
            end
            ST_IDLE: begin
                w_nesc = 1'b1;
            end
            default: begin
                w_nesc = 1'b1;
                w_nesl = 1'b0;
            end
        endcase
    end

    // Phase counter restarts on every state change; poll counter restarts on latch entry.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_phase <= '0;
            r_poll  <= '0;
        end else begin
            if (w_state_next != r_state) r_phase <= '0;
            else                         r_phase <= r_phase + CW'(1);
            if ((w_state_next == ST_LATCH) && (r_state != ST_LATCH)) r_poll <= '0;
            else if (r_poll == POLL_LAST)                             r_poll <= '0;
            else                                                      r_poll <= r_poll + CW'(1);
        end
    end

    // Serial capture of the raw (active-low) frame bits.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_raw     <= 16'h0000;
            r_bit_idx <= 4'd0;
        end else if (w_sample_first) begin
            r_raw[0]  <= r_nesd_s;
            r_bit_idx <= 4'd1;
        end else if (w_sample_next) begin
            r_raw[r_bit_idx] <= r_nesd_s;
            if (r_bit_idx != 4'd15) r_bit_idx <= r_bit_idx + 4'd1;
            else                    r_bit_idx <= r_bit_idx;
        end else begin
            r_raw     <= r_raw;
            r_bit_idx <= r_bit_idx;
        end
    end

    // Registered pins and the atomic result update in the DONE cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            nesc      <= 1'b1;
            nesl      <= 1'b0;
            buttons   <= 16'h0000;
            connected <= 1'b0;
            valid     <= 1'b0;
        end else begin
            nesc  <= w_nesc;
            nesl  <= w_nesl;
            valid <= (r_state == ST_DONE);
            if ((r_state == ST_DONE) && w_present) begin
                buttons   <= {4'b0000, ~r_raw[11:0]};
                connected <= 1'b1;
            end else if (r_state == ST_DONE) begin
                buttons   <= 16'h0000;
                connected <= 1'b0;
            end else begin
                buttons   <= buttons;
                connected <= connected;
            end
        end
    end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Scoreboard bench for snes_pad_reader: a pad model feeds random frames, a
// monitor checks pin timing and pops expected button words on every valid.
module tb_snes_pad_reader;

    localparam int L = 8;
    localparam int H = 4;
    localparam int P = 200;
    localparam int VALID_LATENCY  = 132;
    localparam int NUM_CLK_PULSES = 15;

    logic        clk = 1'b0;
    logic        nreset;
    logic        nesc;
    logic        nesl;
    logic        nesd;
    logic [15:0] buttons;
    logic        connected;
    logic        valid;

    snes_pad_reader #(
        .LATCH_CYCLES(L),
        .HALF_CYCLES (H),
        .POLL_CYCLES (P)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .nesc     (nesc),
        .nesl     (nesl),
        .nesd     (nesd),
        .buttons  (buttons),
        .connected(connected),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_valid  = 0;
    logic [16:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pad model: reloads while latched, shifts on each rising pad clock
    bit          pad_plugged;
    logic [15:0] pad_raw;
    logic [15:0] pad_sr;
    assign nesd = pad_plugged ? pad_sr[0] : 1'b0;

    always @(posedge nesc or posedge nesl) begin
        if (nesl) pad_sr <= pad_raw;
        else      pad_sr <= {1'b1, pad_sr[15:1]};
    end

    // Reference: a present pad reports 1111 in the top four line bits; a pressed
    // button pulls its line low.
    function automatic logic [16:0] ref_frame(input bit plugged, input logic [15:0] raw);
        logic [15:0] line;
        logic [15:0] pressed;
        line    = plugged ? raw : 16'h0000;
        pressed = 16'h0000;
        if (line[15:12] != 4'hF) return 17'h00000;
        for (int i = 0; i < 12; i++) pressed[i] = (line[i] == 1'b0);
        return {1'b1, pressed};
    endfunction

    // Monitor
    logic        p_nesl, p_nesc, p_valid;
    int          rise_cyc, lat_len, lo_len, lo_pulses;
    bit          have_rise, changed;
    logic [16:0] held, mon_exp;

    always @(negedge clk) begin
        if (!nreset) begin
            have_rise = 1'b0; p_nesl = 1'b0; p_nesc = 1'b1; p_valid = 1'b0;
            lat_len = 0; lo_len = 0; lo_pulses = 0; held = 17'h0; changed = 1'b0;
        end else begin
            if (nesl && !p_nesl) begin
                if (have_rise) check("poll_period", cyc - rise_cyc, P);
                have_rise = 1'b1; rise_cyc = cyc; lat_len = 0; lo_pulses = 0;
            end
            if (nesl) lat_len++;
            else if (p_nesl) check("latch_width", lat_len, L);
            if (!nesc) lo_len++;
            else if (!p_nesc) begin
                check("nesc_low_width", lo_len, H);
                lo_pulses++;
                lo_len = 0;
            end
            if (valid) begin
                n_valid++;
                check("valid_width", int'(p_valid), 0);
                check("valid_latency", cyc - rise_cyc, VALID_LATENCY);
                check("nesc_pulse_count", lo_pulses, NUM_CLK_PULSES);
                check("held_between_frames", int'(changed), 0);
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_valid: got valid=1, expected no pending frame (cycle %0d)", cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("buttons", int'(buttons), int'(mon_exp[15:0]));
                    check("connected", int'(connected), int'(mon_exp[16]));
                end
                held = {connected, buttons};
                changed = 1'b0;
            end else if ({connected, buttons} !== held) begin
                changed = 1'b1;
            end
            p_nesl = nesl; p_nesc = nesc; p_valid = valid;
        end
    end

    task automatic apply(input bit plugged, input logic [15:0] raw);
        pad_plugged = plugged;
        pad_raw     = raw;
        exp_q.push_back(ref_frame(plugged, raw));
    endtask

    task automatic wait_valid(input string name);
        int target;
        int t;
        target = n_valid + 1;
        t = 0;
        while (n_valid < target && t < 2 * P) begin
            @(posedge clk);
            t++;
        end
        if (n_valid < target) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: got no valid, expected one within %0d cycles", name, 2 * P);
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nesc"}, int'(nesc), 1);
        check({tag, "_nesl"}, int'(nesl), 0);
        check({tag, "_buttons"}, int'(buttons), 0);
        check({tag, "_connected"}, int'(connected), 0);
        check({tag, "_valid"}, int'(valid), 0);
    endtask

    initial begin
        logic [15:0] raw;
        bit          plugged;
        int          t;

        nreset = 1'b0;
        apply(1'b1, 16'hF5A3);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("nesl_before_first_edge", int'(nesl), 0);
        @(posedge clk);
        #1;
        check("nesl_first_edge", int'(nesl), 1);
        wait_valid("data_f5a3");

        apply(1'b0, 16'($urandom));
        wait_valid("unplugged");
        apply(1'b1, 16'hFFFE);
        wait_valid("plug_fffe");

        for (int i = 0; i < 12; i++) begin
            raw = 16'($urandom);
            if ($urandom_range(0, 3) != 0) raw[15:12] = 4'hF;
            plugged = ($urandom_range(0, 7) != 0);
            apply(plugged, raw);
            wait_valid("random");
        end

        // Abort a frame part-way through the clocking phase
        raw = 16'($urandom);
        raw[15:12] = 4'hF;
        apply(1'b1, raw);
        t = 0;
        while (!nesl && t < 2 * P) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("latch_seen_before_abort", int'(nesl), 1);
        repeat (59) @(posedge clk);
        #1;
        nreset = 1'b0;
        #1;
        check_reset_outputs("midframe");
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("valid_held_low_in_reset", int'(valid), 0);
        raw = 16'($urandom);
        raw[15:12] = 4'hF;
        apply(1'b1, raw);
        @(negedge clk);
        nreset = 1'b1;
        wait_valid("after_reset");
        apply(1'b1, 16'hF000);
        wait_valid("all_pressed");
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
